// File: rtl/pipeline_skid_buffer.sv
// Two-entry pipeline skid buffer.
// Breaks the ready/valid timing path: input_ready, output_valid and
// output_data all come straight from flip-flops. A second (skid) register
// catches the word that arrives in the cycle downstream stalls.
module pipeline_skid_buffer #(
  parameter int unsigned            WORD_WIDTH  = 0,
  parameter logic [WORD_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  localparam logic [1:0] EMPTY = 2'd0;  // nothing held
  localparam logic [1:0] BUSY  = 2'd1;  // output register valid
  localparam logic [1:0] FULL  = 2'd2;  // output and skid registers valid

  logic [1:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic [WORD_WIDTH-1:0] skid_data_q, skid_data_d;

  logic insert_s;
  logic remove_s;

  // Handshakes use only the registered ready/valid, so unqualified
  // input_valid/output_ready are ignored when their partner is low.
  assign insert_s = input_valid & in_ready_q;
  assign remove_s = out_valid_q & output_ready;

  // Next-state and data-load decisions for the three-state controller.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: begin
        if (insert_s) begin
          state_d    = BUSY;
          out_data_d = input_data;
        end else begin
          state_d = EMPTY;
        end
      end
      BUSY: begin
        if (insert_s && remove_s) begin
          state_d    = BUSY;
          out_data_d = input_data;
        end else if (insert_s) begin
          // Downstream stalled: park the new word in the skid register.
          state_d     = FULL;
          skid_data_d = input_data;
        end else if (remove_s) begin
          state_d = EMPTY;
        end else begin
          state_d = BUSY;
        end
      end
      FULL: begin
        if (remove_s) begin
          state_d    = BUSY;
          out_data_d = skid_data_q;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Ready/valid are decoded from the next state so they can be registered.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    case (state_d)
      EMPTY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      BUSY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
      end
      FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and data registers; areset beats clear, clear beats any transfer.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_VALUE;
      skid_data_q <= RESET_VALUE;
    end else if (clear) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_VALUE;
      skid_data_q <= RESET_VALUE;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign input_ready  = in_ready_q;
  assign output_valid = out_valid_q;
  assign output_data  = out_data_q;

endmodule
